// File: rtl/uart_rx_control.sv
// UART receive engine: start qualification, LSB-first data, optional parity, 1/1.5/2 stop bits.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote of the ticks around each bit middle.
module uart_rx_control #(
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLING   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic [1:0]            parity_select,
  input  logic [1:0]            stop_select,
  input  logic                  s_data_in,
  output logic [DATA_WIDTH-1:0] p_data_out,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int TW = $clog2(SAMPLING + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef RX_MAJORITY_VOTE_EN
  // Decide one tick after the middle; reload to 1 so the bit-middle reference stays put.
  localparam logic [TW-1:0] START_DEC = TW'(SAMPLING / 2);
  localparam logic [TW-1:0] BIT_DEC   = TW'(SAMPLING);
  localparam logic [TW-1:0] RELOAD    = TW'(1);
`else
  localparam logic [TW-1:0] START_DEC = TW'(SAMPLING / 2 - 1);
  localparam logic [TW-1:0] BIT_DEC   = TW'(SAMPLING - 1);
  localparam logic [TW-1:0] RELOAD    = '0;
`endif

  state_t                  state_q, state_d;
  logic                    sync1_q, sync2_q;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [1:0]              par_sel_q, par_sel_d;
  logic [1:0]              stop_sel_q, stop_sel_d;
  logic                    par_bad_q, par_bad_d;
  logic                    stop_bad_q, stop_bad_d;
  logic                    stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    valid_q, valid_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;

  logic rx_s;
  logic sample;
  logic par_en, par_odd, two_stops, exp_par, stop_bad_now;

  assign rx_s = sync2_q;

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q, hist_d;
  always_comb begin
    hist_d = hist_q;
    if (bclk) hist_d = {hist_q[0], rx_s};
  end
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
  always_ff @(posedge clk) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  assign sample = rx_s;
`endif

  assign par_en       = (par_sel_q == 2'b01) || (par_sel_q == 2'b10);
  assign par_odd      = (par_sel_q == 2'b10);
  assign two_stops    = (stop_sel_q == 2'b10) || (stop_sel_q == 2'b11);
  assign exp_par      = par_odd ? ~(^shift_q) : (^shift_q);
  assign stop_bad_now = stop_bad_q | ~sample;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_sel_d  = par_sel_q;
    stop_sel_d = stop_sel_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    stop2_d    = stop2_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (bclk) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_d     = '0;
            par_sel_d  = parity_select;
            stop_sel_d = stop_select;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
            stop2_d    = 1'b0;
          end
        end
        START: begin
          if (tick_q == START_DEC) begin
            if (sample) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = RELOAD;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == BIT_DEC) begin
            tick_d  = RELOAD;
            shift_d = {sample, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == BW'(DATA_WIDTH - 1)) state_d = par_en ? PARITY : STOP;
            else                              bit_d   = bit_q + BW'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        PARITY: begin
          if (tick_q == BIT_DEC) begin
            tick_d    = RELOAD;
            par_bad_d = (sample != exp_par);
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == BIT_DEC) begin
            tick_d = RELOAD;
            if (two_stops && !stop2_q) begin
              stop2_d    = 1'b1;
              stop_bad_d = stop_bad_now;
            end else begin
              // Completion registers everything at this edge so IDLE is live next cycle.
              state_d    = IDLE;
              valid_d    = 1'b1;
              data_out_d = shift_q;
              perr_d     = par_bad_q;
              ferr_d     = stop_bad_now;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_sel_q  <= '0;
      stop_sel_q <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      stop2_q    <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= s_data_in;
      sync2_q    <= sync1_q;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_sel_q  <= par_sel_d;
      stop_sel_q <= stop_sel_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      stop2_q    <= stop2_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign p_data_out = data_out_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule
